issue_scoreboard: RTL and testbench



---
 rtl/constants_pkg.sv | 9 +
 rtl/instruction_pkg.sv | 12 +
 rtl/scoreboard_entry.sv | 62 ++++++
 rtl/issue_scoreboard.sv | 131 +++++++++++++
 tb/tb_issue_scoreboard.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/constants_pkg.sv
// Shared machine constants: register file size and default producer latencies.
package constants_pkg;

  localparam int unsigned REG_FILE_LEN = 32;
  localparam int unsigned ALU_LAT      = 1;
  localparam int unsigned LOAD_LAT     = 2;
  localparam int unsigned MUL_LAT      = 5;

endpackage

// File: rtl/instruction_pkg.sv
// Instruction-level types shared by decode and the issue scoreboard.
package instruction_pkg;

  // Producer class of the instruction in decode; 3 is reserved and handled as MUL.
  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSVD = 2'd3
  } prod_class_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard slot: pending-write bit and, with SCOREBOARD_BYPASS_EN defined,
// a countdown to the cycle the producer's result becomes forwardable.
// Ports: clk, rst (async, active-low), set / clear / flush controls,
//        load (countdown start value, bypass build), pending and cnt state outputs.
// Priority per edge: flush > set > clear > countdown.
`ifdef SCOREBOARD_BYPASS_EN
module scoreboard_entry #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [CNT_W-1:0] load,
  input  logic             clear,
  input  logic             flush,
  output logic             pending,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else if (flush) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else if (set) begin
      pending <= 1'b1;
      cnt     <= load;
    end else if (clear) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else if (pending && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule
`else
module scoreboard_entry (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clear,
  input  logic flush,
  output logic pending
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (flush) begin
      pending <= 1'b0;
    end else if (set) begin
      pending <= 1'b1;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/issue_scoreboard.sv
// Register-dependency scoreboard and issue controller beside decode.
// Decides each cycle whether the decode instruction issues or stalls on RAW/WAW.
// Optional macro SCOREBOARD_BYPASS_EN: RAW dependents release once the producer's
// result is forwardable (per-register latency countdowns); otherwise they wait
// for writeback. WAW always waits for writeback.
// Ports: clk, rst (async, active-low); dec_* decode instruction fields;
//        wb_valid/wb_dst writeback; flush; issue_stall/issue_fire (combinational);
//        busy (pending-write vector), stall_cycles (saturating stall count).
module issue_scoreboard
  import instruction_pkg::*;
#(
  parameter int unsigned NUM_REGS = constants_pkg::REG_FILE_LEN,
  parameter int unsigned ALU_LAT  = constants_pkg::ALU_LAT,
  parameter int unsigned LOAD_LAT = constants_pkg::LOAD_LAT,
  parameter int unsigned MUL_LAT  = constants_pkg::MUL_LAT,
  parameter int unsigned CNT_W    = $clog2(MUL_LAT),
  localparam int unsigned RW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [RW-1:0]       dec_src1,
  input  logic [RW-1:0]       dec_src2,
  input  logic                dec_use_src1,
  input  logic                dec_use_src2,
  input  logic [RW-1:0]       dec_dst,
  input  logic                dec_writes,
  input  logic [1:0]          dec_class,
  input  logic                wb_valid,
  input  logic [RW-1:0]       wb_dst,
  input  logic                flush,
  output logic                issue_stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] busy,
  output logic [31:0]         stall_cycles
);

  logic [NUM_REGS-1:0] pend;
  logic                raw1;
  logic                raw2;
  logic                waw;

  assign pend[0] = 1'b0;

`ifdef SCOREBOARD_BYPASS_EN
  // blk[r]: producer result of r is not yet forwardable.
  logic [NUM_REGS-1:0] blk;
  prod_class_t         cls;
  logic [CNT_W-1:0]    load_val;

  assign blk[0] = 1'b0;
  assign cls    = prod_class_t'(dec_class);

  // Countdown start value for the issuing producer.
  always_comb begin
    load_val = CNT_W'(MUL_LAT - 1);
    case (cls)
      CLS_ALU:  load_val = CNT_W'(ALU_LAT - 1);
      CLS_LOAD: load_val = CNT_W'(LOAD_LAT - 1);
      default:  load_val = CNT_W'(MUL_LAT - 1);
    endcase
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{dec_class, 32'(ALU_LAT), 32'(LOAD_LAT), 32'(MUL_LAT), 32'(CNT_W)};
`endif

  // Hazards from registered state only.
  always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
    raw1 = dec_use_src1 & pend[dec_src1] & blk[dec_src1];
    raw2 = dec_use_src2 & pend[dec_src2] & blk[dec_src2];
`else
    raw1 = dec_use_src1 & pend[dec_src1];
    raw2 = dec_use_src2 & pend[dec_src2];
`endif
    waw  = dec_writes & pend[dec_dst];
  end

  assign issue_stall = dec_valid & ~flush & (raw1 | raw2 | waw);
  assign issue_fire  = dec_valid & ~flush & ~issue_stall;

  // Register 0 has no entry, so writes to x0 never mark it pending.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic set_en;
    logic clr_en;

    assign set_en = issue_fire & dec_writes & (dec_dst == RW'(r));
    assign clr_en = wb_valid & (wb_dst == RW'(r));

`ifdef SCOREBOARD_BYPASS_EN
    logic [CNT_W-1:0] cnt;

    scoreboard_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .set     (set_en),
      .load    (load_val),
      .clear   (clr_en),
      .flush   (flush),
      .pending (pend[r]),
      .cnt     (cnt)
    );

    assign blk[r] = (cnt != '0);
`else
    scoreboard_entry u_entry (
      .clk     (clk),
      .rst     (rst),
      .set     (set_en),
      .clear   (clr_en),
      .flush   (flush),
      .pending (pend[r])
    );
`endif
  end

  assign busy = pend;

  // Saturating stall counter; survives flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (issue_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard (either SCOREBOARD_BYPASS_EN build).
module tb_issue_scoreboard;
  import instruction_pkg::*;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_src1;
  logic [4:0]  dec_src2;
  logic        dec_use_src1;
  logic        dec_use_src2;
  logic [4:0]  dec_dst;
  logic        dec_writes;
  logic [1:0]  dec_class;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic        flush;
  logic        issue_stall;
  logic        issue_fire;
  logic [31:0] busy;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_total = 0;
  int exp_q[$];

  issue_scoreboard u_dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_src1     (dec_src1),
    .dec_src2     (dec_src2),
    .dec_use_src1 (dec_use_src1),
    .dec_use_src2 (dec_use_src2),
    .dec_dst      (dec_dst),
    .dec_writes   (dec_writes),
    .dec_class    (dec_class),
    .wb_valid     (wb_valid),
    .wb_dst       (wb_dst),
    .flush        (flush),
    .issue_stall  (issue_stall),
    .issue_fire   (issue_fire),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected stalls of a RAW dependent: bypass releases after LAT-1 cycles,
  // otherwise one cycle after the writeback cycle.
  function automatic int dep_stalls(input int lat, input int wb_at);
    return BYP ? (lat - 1) : (wb_at + 1);
  endfunction

  // Present one instruction from cycle start (posedge+1) until it fires.
  // A writeback of wb_reg is driven during the wb_at-th presented cycle.
  task automatic present(input string tag, input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2, input logic [4:0] dst,
                         input logic wr, input prod_class_t cls, input int wb_at,
                         input logic [4:0] wb_reg, input int exp_stalls);
    int  n;
    bit  fired;
    exp_q.push_back(exp_stalls);
    exp_total += exp_stalls;
    dec_valid = 1'b1;
    dec_src1 = s1; dec_use_src1 = u1;
    dec_src2 = s2; dec_use_src2 = u2;
    dec_dst = dst; dec_writes = wr; dec_class = cls;
    n = 0;
    fired = 1'b0;
    for (int k = 0; k < 40 && !fired; k++) begin
      wb_valid = (k == wb_at);
      wb_dst   = wb_reg;
      @(negedge clk);
      if (issue_fire) fired = 1'b1;
      else if (issue_stall) n++;
      @(posedge clk);
      #1;
    end
    dec_valid = 1'b0;
    wb_valid  = 1'b0;
    if (!fired) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    check_eq({tag, "_stalls"}, 32'(n), 32'(exp_q.pop_front()));
  endtask

  task automatic writeback(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_dst   = r;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; flush = 1'b0;
    dec_valid = 1'b0; dec_src1 = '0; dec_src2 = '0; dec_use_src1 = 1'b0;
    dec_use_src2 = 1'b0; dec_dst = '0; dec_writes = 1'b0; dec_class = '0;
    wb_valid = 1'b0; wb_dst = '0;

    // Reset state
    #12;
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_stallcnt", stall_cycles, 32'd0);
    check_eq("rst_stall", 32'(issue_stall), 32'd0);
    check_eq("rst_fire", 32'(issue_fire), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // First instruction after reset issues immediately
    present("first", 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, CLS_ALU, -1, 5'd0, 0);
    check_eq("first_busy", busy, 32'd0);
    check_eq("first_stallcnt", stall_cycles, 32'd0);

    // ALU producer then dependent
    present("add5", 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, CLS_ALU, -1, 5'd0, 0);
    check_eq("add5_busy", busy, 32'h0000_0020);
    present("add6", 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, CLS_ALU, 1, 5'd5, dep_stalls(1, 1));
    writeback(5'd5);
    writeback(5'd6);
    check_eq("alu_clr_busy", busy, 32'd0);

    // Load producer then dependent
    present("lw7", 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, CLS_LOAD, -1, 5'd0, 0);
    present("add8", 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, CLS_ALU, 3, 5'd7, dep_stalls(2, 3));
    check_eq("load_stallcnt", stall_cycles, 32'(exp_total));
    writeback(5'd7);
    writeback(5'd8);

    // Multiply producer then dependent; busy[9] holds until its writeback
    present("mul9", 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, CLS_MUL, -1, 5'd0, 0);
    present("sub10", 5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, CLS_ALU, 6, 5'd9, dep_stalls(5, 6));
    check_eq("mul_busy9", 32'(busy[9]), BYP ? 32'd1 : 32'd0);
    writeback(5'd9);
    check_eq("mul_busy9_wb", 32'(busy[9]), 32'd0);
    writeback(5'd10);
    check_eq("mul_stallcnt", stall_cycles, 32'(exp_total));

    // WAW: second writer to x11 waits for the first writeback plus a cycle
    present("add11a", 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, CLS_ALU, -1, 5'd0, 0);
    present("add11b", 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, CLS_ALU, 2, 5'd11, 3);
    check_eq("waw_busy", busy, 32'h0000_0800);
    writeback(5'd11);

    // Writes to x0 never mark it busy nor cause WAW
    present("x0a", 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, CLS_MUL, -1, 5'd0, 0);
    present("x0b", 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, CLS_ALU, -1, 5'd0, 0);
    check_eq("x0_busy", busy, 32'd0);

    // Reserved class is a multiply
    present("rsv13", 5'd1, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, CLS_RSVD, -1, 5'd0, 0);
    present("dep13", 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, CLS_ALU, 6, 5'd13, dep_stalls(5, 6));
    writeback(5'd13);
    writeback(5'd14);

    // Flush during a pending multiply
    present("mul12", 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, CLS_MUL, -1, 5'd0, 0);
    flush = 1'b1;
    dec_valid = 1'b1; dec_src1 = 5'd12; dec_use_src1 = 1'b1; dec_writes = 1'b0;
    @(negedge clk);
    check_eq("flush_stall", 32'(issue_stall), 32'd0);
    check_eq("flush_fire", 32'(issue_fire), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; dec_valid = 1'b0;
    check_eq("flush_busy", busy, 32'd0);
    present("dep12", 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, CLS_ALU, -1, 5'd0, 0);
    check_eq("flush_stallcnt", stall_cycles, 32'(exp_total));

    // Reset asserted mid-stall clears state asynchronously
    present("mul15", 5'd1, 1'b1, 5'd2, 1'b1, 5'd15, 1'b1, CLS_MUL, -1, 5'd0, 0);
    dec_valid = 1'b1; dec_src1 = 5'd15; dec_use_src1 = 1'b1;
    dec_src2 = 5'd0; dec_use_src2 = 1'b0; dec_writes = 1'b0;
    @(negedge clk);
    check_eq("midrst_stall_pre", 32'(issue_stall), 32'd1);
    check_eq("midrst_stallcnt_pre", stall_cycles, 32'(exp_total));
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 32'd0);
    check_eq("midrst_stallcnt", stall_cycles, 32'd0);
    check_eq("midrst_fire", 32'(issue_fire), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    dec_valid = 1'b0;
    present("post_rst", 5'd15, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, CLS_ALU, -1, 5'd0, 0);
    check_eq("post_rst_busy", busy, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
